quotient_bcd_converter: RTL
===========================

# quotient_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the long-division unit. It captures the divider's quotient and error flag when `done` pulses, converts the quotient to packed BCD with the shift-and-add-3 (double-dabble) algorithm, one bit per clock, and presents the digits to the display/output logic. A divider error bypasses conversion and produces an all-`F` error pattern.

## Interface
- `SIZE`, 32: width of the binary input; matches the divider's quotient width.
- `DIGITS`, 10: number of BCD digits; must satisfy 10^DIGITS > 2^SIZE − 1 (10 for SIZE = 32).
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  input  1  load request; driven by the divider's `done`.
- `bin_in`  input  SIZE  binary value to convert (divider quotient).
- `error_in`  input  1  divider error flag, sampled with `start`.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `bcd_out` and `err_out` are valid.
- `bcd_out`  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- `err_out`  output  1  high when the held result is the error pattern.

## Operation
- States: IDLE, CONVERT, FINISH.
- IDLE: `busy` = 0. If `start` = 1:
  - `error_in` = 0: load shift register {BCD = 0, BIN = `bin_in`}, set counter to SIZE, go to CONVERT.
  - `error_in` = 1: go to FINISH with the error flag set.
- CONVERT: each cycle, add 3 to every BCD digit ≥ 5, then shift {BCD, BIN} left by 1 and decrement the counter. After SIZE shifts, go to FINISH.
- FINISH: register `bcd_out` and `err_out`, assert `done` for exactly one cycle, return to IDLE.
  - Normal result: `bcd_out` = BCD field, `err_out` = 0.
  - Error result: `bcd_out` = all `4'hF`, `err_out` = 1.
- `bcd_out` and `err_out` hold until the next FINISH. They do not change during a later conversion.
- `start` while `busy` = 1 is ignored. No queueing.
- Internal BCD register width is 4*DIGITS. The add-3 is applied to all digits in parallel, and no digit ever exceeds 9 after a shift.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `bcd_out` = 0, `err_out` = 0, counter = 0.
- Reset mid-conversion: abort on that edge. The pending result is discarded, no `done` pulse is issued, and outputs are cleared.
- Normal latency: `start` sampled at edge k.
  - `busy` is high from edge k to edge k+SIZE+1.
  - `bcd_out` is updated at edge k+SIZE+1.
  - `done` is high for the cycle after edge k+SIZE+1, i.e. SIZE+2 edges from start to the end of the `done` cycle.
- Error latency: `start` with `error_in` sampled at edge k.
  - Outputs are updated at edge k+1.
  - `done` is high for one cycle after edge k+1.
- Back-to-back: a `start` sampled during the `done` cycle (state IDLE) is accepted.
- `done` and `busy` are never high in the same cycle.

## Structure
- Shared package:
  - state encoding constants (IDLE, CONVERT, FINISH);
  - error digit constant `4'hF`;
  - default SIZE/DIGITS.
- Sub-module `bcd_digit_adjust`: combinational 4-bit in/out, adds 3 when the input is ≥ 5. It is instantiated DIGITS times with a generate loop.
- Top level holds the FSM, counter (width ⌈log2(SIZE+1)⌉), shift register, and output registers.

## Test plan
- `bin_in` = 0, `start` pulse → `done` after 34 edges, `bcd_out` = 40'h0000000000, `err_out` = 0.
- `bin_in` = 1234 → `bcd_out` = 40'h0000001234. Then `bin_in` = 4294967295 back-to-back (start during `done` cycle) → `bcd_out` = 40'h4294967295.
- `error_in` = 1 with `start` → `done` on the cycle after edge k+1, `bcd_out` = 40'hFFFFFFFFFF, `err_out` = 1. A following normal `start` with 7 → 40'h0000000007, `err_out` = 0.
- `start` pulsed 5 cycles into a conversion of 99 with `bin_in` = 55 → ignored; result is 40'h0000000099 and only one `done` pulse occurs.
- `reset` asserted 10 cycles into a conversion → next edge: `busy` = 0, `bcd_out` = 0, no `done`. A new `start` with 100 → 40'h0000000100.
- Random sweep: 1000 random 32-bit values checked against a reference decimal model; `done` is exactly one cycle each time.

Source files
------------

// File: rtl/quotient_bcd_converter_pkg.sv
// Shared constants for the quotient-to-BCD converter: FSM encodings,
// the error digit and default sizing matching the divider's quotient.
package quotient_bcd_converter_pkg;

    localparam int DEFAULT_SIZE   = 32;
    localparam int DEFAULT_DIGITS = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CONVERT = 2'd1;
    localparam state_t ST_FINISH  = 2'd2;

    localparam logic [3:0] ERR_DIGIT = 4'hF;

    // A digit of 5 or more would overflow past 9 after doubling, so it gets +3 first.
    function automatic logic needs_adjust(input logic [3:0] digit);
        return digit >= 4'd5;
    endfunction

endpackage

// File: rtl/quotient_bcd_converter_bcd_digit_adjust.sv
// Combinational add-3 correction for one BCD digit ahead of a
// double-dabble shift.
module bcd_digit_adjust
    import quotient_bcd_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (needs_adjust(digit_in)) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/quotient_bcd_converter.sv
// Captures the divider quotient on start and converts it to packed BCD one
// bit per clock; a divider error skips conversion and yields an all-F result.
module quotient_bcd_converter
    import quotient_bcd_converter_pkg::*;
#(
    parameter int SIZE   = DEFAULT_SIZE,
    parameter int DIGITS = DEFAULT_DIGITS
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SIZE-1:0]       bin_in,
    input  logic                  error_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  err_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + SIZE;
    localparam int CNT_W = $clog2(SIZE + 1);

    state_t            state_q, state_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              err_q, err_d;
    logic              err_pending_q, err_pending_d;
    logic              done_q, done_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [SR_W-1:0]   shift_adj;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (shift_q[SIZE + 4*gi +: 4]),
                .digit_out (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign shift_adj = {bcd_adj, shift_q[SIZE-1:0]};

    // Output registers only change in FINISH, so results hold through later conversions.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        count_d       = count_q;
        bcd_d         = bcd_q;
        err_d         = err_q;
        err_pending_d = err_pending_q;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (error_in) begin
                        err_pending_d = 1'b1;
                        state_d       = ST_FINISH;
                    end else begin
                        err_pending_d = 1'b0;
                        shift_d       = {{BCD_W{1'b0}}, bin_in};
                        count_d       = CNT_W'(SIZE);
                        state_d       = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                shift_d = shift_adj << 1;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d = 1'b1;
                if (err_pending_q) begin
                    bcd_d = {DIGITS{ERR_DIGIT}};
                    err_d = 1'b1;
                end else begin
                    bcd_d = shift_q[SR_W-1:SIZE];
                    err_d = 1'b0;
                end
                err_pending_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            count_q       <= '0;
            bcd_q         <= '0;
            err_q         <= 1'b0;
            err_pending_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            bcd_q         <= bcd_d;
            err_q         <= err_d;
            err_pending_q <= err_pending_d;
            done_q        <= done_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign err_out = err_q;

endmodule
